// File: rtl/matrix_scan_capture.sv
// Rebuilds the 5x7 frame from the multiplexed LED column scan and flags malformed or stuck scans.
// Latency: frame_valid rises SETTLE+3 clocks after column 4 reaches the pins; backpressure: an unacked frame blocks the next one (overrun pulse).
module matrix_scan_capture #(
    parameter bit COL_ACTIVE_LOW = 1'b1,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter int SETTLE         = 2,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  col,
    input  logic [6:0]  row,
    output logic [34:0] frame,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic        scan_err,
    output logic        overrun
);

    typedef enum logic {HUNT, SCAN} state_t;

    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_FIRE  = {{(TO_W-1){1'b1}}, 1'b0};

    // Polarity is folded in ahead of the synchronizer so its reset value reads as blanking.
    logic [4:0] colIn;
    logic [6:0] rowIn;
    assign colIn = col ^ {5{COL_ACTIVE_LOW}};
    assign rowIn = row ^ {7{ROW_ACTIVE_LOW}};

    logic [4:0] colMeta, colSync, evtCol;
    logic [6:0] rowMeta, rowSync, evtRow;
    logic [3:0] stabCnt;
    logic       evtVld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colMeta <= '0;
            colSync <= '0;
            rowMeta <= '0;
            rowSync <= '0;
            stabCnt <= '0;
            evtVld  <= 1'b0;
            evtCol  <= '0;
            evtRow  <= '0;
        end else begin
            colMeta <= colIn;
            colSync <= colMeta;
            rowMeta <= rowIn;
            rowSync <= rowMeta;
            if (colMeta != colSync) begin
                stabCnt <= '0;
            end else if (stabCnt != SETTLE_C) begin
                stabCnt <= stabCnt + 4'd1;
            end
            // Fires on the clock the counter lands on SETTLE, so once per dwell.
            evtVld <= (colMeta == colSync) && (stabCnt == SETTLE_C - 4'd1);
            evtCol <= colSync;
            evtRow <= rowSync;
        end
    end

    logic       blankCol, multiCol;
    logic [2:0] colIdx;

    always_comb begin
        colIdx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (evtCol[i]) colIdx = 3'(i);
        end
    end

    assign blankCol = (evtCol == 5'd0);
    assign multiCol = |(evtCol & (evtCol - 5'd1));

    state_t          state, stateNxt;
    logic [2:0]      expIdx, expNxt;
    logic [TO_W-1:0] toCnt;
    logic [34:0]     asmBuf;
    logic            errNxt, capture, complete;

    always_comb begin
        stateNxt = state;
        expNxt   = expIdx;
        errNxt   = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;
        if (evtVld && !blankCol) begin
            if (multiCol) begin
                errNxt   = 1'b1;
                stateNxt = HUNT;
                expNxt   = 3'd0;
            end else if (state == HUNT) begin
                if (colIdx == 3'd0) begin
                    capture  = 1'b1;
                    expNxt   = 3'd1;
                    stateNxt = SCAN;
                end
            end else if (colIdx == expIdx) begin
                capture = 1'b1;
                if (colIdx == 3'd4) begin
                    complete = 1'b1;
                    expNxt   = 3'd0;
                end else begin
                    expNxt = expIdx + 3'd1;
                end
            end else begin
                errNxt = 1'b1;
                // An out-of-order column 0 is the start of a new frame, not a dead scan.
                if (colIdx == 3'd0) begin
                    capture = 1'b1;
                    expNxt  = 3'd1;
                end else begin
                    stateNxt = HUNT;
                    expNxt   = 3'd0;
                end
            end
        end else if (state == SCAN && toCnt == TO_FIRE) begin
            errNxt   = 1'b1;
            stateNxt = HUNT;
            expNxt   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            expIdx <= 3'd0;
            toCnt  <= '0;
            asmBuf <= '0;
        end else begin
            state  <= stateNxt;
            expIdx <= expNxt;
            toCnt  <= (capture || stateNxt == HUNT) ? '0 : toCnt + TO_ONE;
            for (int k = 0; k < 5; k++) begin
                if (capture && colIdx == 3'(k)) asmBuf[7*k +: 7] <= evtRow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            scan_err <= errNxt;
            overrun  <= 1'b0;
            if (complete) begin
                // Column 4 rows come straight from the event; the slot write lands this same clock.
                if (!frame_valid || frame_ack) begin
                    frame       <= {evtRow, asmBuf[27:0]};
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
